// File: rtl/tkm10_uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling, ready/valid output with sticky error flags.
// Optional even parity (8E1) when TKM10_RX_PARITY_EN is defined; default frame is 8N1.
module tkm10_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    input  logic       err_clr_i,
    output logic       frame_err_o,
    output logic       overrun_o,
`ifdef TKM10_RX_PARITY_EN
    output logic       parity_err_o,
`endif
    output logic       busy_o
);

    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef TKM10_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          rx_meta_q, rx_s_q;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          stop_sample;
    logic          parity_ok;
    logic          commit_ok;
    logic          handshake;
`ifdef TKM10_RX_PARITY_EN
    logic          par_q, par_d;
    logic          parity_err_q, parity_err_d;
`endif

    // Synchronizer flops reset high so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef TKM10_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        stop_sample = 1'b0;
`ifdef TKM10_RX_PARITY_EN
        par_d       = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                timer_d  = '0;
                bitcnt_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DATA: begin
                if (timer_q == BIT_LAST) begin
                    timer_d  = '0;
                    shift_d  = {rx_s_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
`ifdef TKM10_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
`ifdef TKM10_RX_PARITY_EN
            S_PARITY: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    par_d   = rx_s_q;
                    state_d = S_STOP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
`endif
            S_STOP: begin
                // Return straight to IDLE so a start bit right after the stop bit is caught.
                if (timer_q == BIT_LAST) begin
                    timer_d     = '0;
                    stop_sample = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

`ifdef TKM10_RX_PARITY_EN
    assign parity_ok = (par_q == ^shift_q);
`else
    assign parity_ok = 1'b1;
`endif

    assign handshake = valid_q & ready_i;
    assign commit_ok = stop_sample & rx_s_q & parity_ok;

    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = frame_err_q & ~err_clr_i;
        overrun_d   = overrun_q & ~err_clr_i;
        if (handshake) begin
            valid_d = 1'b0;
        end
        // A commit coinciding with a handshake refills the slot; otherwise a full slot drops the byte.
        if (commit_ok) begin
            if (!valid_q || handshake) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (stop_sample && !rx_s_q) begin
            frame_err_d = 1'b1;
        end
    end

`ifdef TKM10_RX_PARITY_EN
    always_comb begin
        parity_err_d = parity_err_q & ~err_clr_i;
        if (stop_sample && !parity_ok) begin
            parity_err_d = 1'b1;
        end
    end

    assign parity_err_o = parity_err_q;
`endif

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_tkm10_uart_rx.sv
// Directed self-checking bench for tkm10_uart_rx at CLKS_PER_BIT=16.
// Parity scenarios are compiled in when TKM10_RX_PARITY_EN is defined.
module tb_tkm10_uart_rx;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       err_clr_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;
`ifdef TKM10_RX_PARITY_EN
    logic       parity_err_o;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] log_q[$];
    bit         log_en = 1'b0;

    tkm10_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .err_clr_i   (err_clr_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
`ifdef TKM10_RX_PARITY_EN
        .parity_err_o(parity_err_o),
`endif
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    // Record each byte that will be accepted at the next rising edge.
    always @(negedge clk) begin
        if (log_en && valid_o && ready_i) log_q.push_back(data_o);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx_i = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef TKM10_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop_b);
        rx_i = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; rx_i = 1'b1; ready_i = 1'b0; err_clr_i = 1'b0;
        idle(3);
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun_o); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_basic;
        ready_i = 1'b0;
        send_frame(8'hA5, 1'b1);
        idle(2);
        checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", data_o); end
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", valid_o); end
        idle(40);
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid_held: got %b expected 1", valid_o); end
        checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL basic_data_held: got %h expected a5", data_o); end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL basic_valid_after_hs: got %b expected 0", valid_o); end
        idle(5);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL basic_valid_stays_low: got %b expected 0", valid_o); end
    endtask

    task automatic test_glitch;
        rx_i = 1'b0;
        idle(4);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL glitch_busy: got %b expected 1", busy_o); end
        rx_i = 1'b1;
        idle(20);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b expected 0", busy_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b expected 0", valid_o); end
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL glitch_frame_err: got %b expected 0", frame_err_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL glitch_overrun: got %b expected 0", overrun_o); end
    endtask

    task automatic test_frame_err;
        ready_i = 1'b0;
        send_frame(8'h3C, 1'b0);
        idle(30);
        checks++; if (frame_err_o !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b expected 1", frame_err_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL ferr_valid: got %b expected 0", valid_o); end
        checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL ferr_data_kept: got %h expected a5", data_o); end
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b expected 0", frame_err_o); end
    endtask

    task automatic test_overrun;
        ready_i = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(4);
        checks++; if (data_o !== 8'h11) begin errors++; $display("FAIL ovr_data: got %h expected 11", data_o); end
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b expected 1", valid_o); end
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", overrun_o); end
        ready_i = 1'b1; err_clr_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0; err_clr_i = 1'b0;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL ovr_consumed: got %b expected 0", valid_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", overrun_o); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] got0, got1;
        log_q.delete();
        ready_i = 1'b1;
        log_en = 1'b1;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(4);
        log_en = 1'b0;
        ready_i = 1'b0;
        got0 = (log_q.size() > 0) ? log_q[0] : 8'hxx;
        got1 = (log_q.size() > 1) ? log_q[1] : 8'hxx;
        checks++; if (log_q.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", log_q.size()); end
        checks++; if (got0 !== 8'h11) begin errors++; $display("FAIL b2b_first: got %h expected 11", got0); end
        checks++; if (got1 !== 8'h22) begin errors++; $display("FAIL b2b_second: got %h expected 22", got1); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", overrun_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL b2b_valid: got %b expected 0", valid_o); end
    endtask

    task automatic test_reset_midframe;
        ready_i = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rx_i = 1'b1;
        idle(8);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", busy_o); end
        rst = 1'b1;
        idle(3);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy_reset: got %b expected 0", busy_o); end
        rst = 1'b0;
        idle(100);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_no_byte: got %b expected 0", valid_o); end
        send_frame(8'h5A, 1'b1);
        idle(2);
        checks++; if (data_o !== 8'h5A) begin errors++; $display("FAIL rstmid_data: got %h expected 5a", data_o); end
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL rstmid_valid: got %b expected 1", valid_o); end
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL rstmid_frame_err: got %b expected 0", frame_err_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL rstmid_overrun: got %b expected 0", overrun_o); end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
    endtask

`ifdef TKM10_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par_b);
        send_bit(1'b1);
        rx_i = 1'b1;
    endtask

    task automatic test_parity;
        ready_i = 1'b0;
        send_frame_par(8'h07, 1'b1);
        idle(2);
        checks++; if (data_o !== 8'h07) begin errors++; $display("FAIL par_good_data: got %h expected 07", data_o); end
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL par_good_valid: got %b expected 1", valid_o); end
        checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL par_good_flag: got %b expected 0", parity_err_o); end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        send_frame_par(8'h07, 1'b0);
        idle(2);
        checks++; if (parity_err_o !== 1'b1) begin errors++; $display("FAIL par_bad_flag: got %b expected 1", parity_err_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL par_bad_valid: got %b expected 0", valid_o); end
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL par_clear: got %b expected 0", parity_err_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
`ifdef TKM10_RX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tkm10_uart_rx.md
TKM10_UART_RX -- requirements
Module: tkm10_uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit (even integer, minimum 4).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rx_i  input  1  asynchronous serial line (ui_in[0] of tt_um_tkm10); idle high.
REQ-005 data_o  output  8  received byte presented to the downstream core.
REQ-006 valid_o  output  1  data_o holds an unconsumed byte.
REQ-007 ready_i  input  1  downstream accepts data_o when valid_o and ready_i are both high.
REQ-008 err_clr_i  input  1  clears the sticky error flags.
REQ-009 frame_err_o  output  1  sticky flag: stop bit sampled low.
REQ-010 overrun_o  output  1  sticky flag: byte completed while valid_o was high and ready_i low.
REQ-011 busy_o  output  1  high in every state except IDLE.

Function
REQ-012 rx_i shall pass through a 2-flop synchronizer; all logic below uses the synchronized value rx_s.
REQ-013 FSM states: IDLE, START, DATA, PARITY (only when macro defined), STOP.
REQ-014 IDLE: rx_s low -> START, bit-timer cleared.
REQ-015 START: at bit-timer = CLKS_PER_BIT/2-1, sample rx_s; high = false start -> IDLE with no flag; low -> DATA, timer cleared.
REQ-016 DATA: sample rx_s every CLKS_PER_BIT cycles; 8 bits LSB first into a shift register; after bit 7 -> PARITY or STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles, sample rx_s; then -> IDLE in the same transition, so back-to-back frames are received.
REQ-018 Stop high and no parity error: byte shall be committed to data_o/valid_o in the cycle after the stop sample.
REQ-019 Stop low: byte discarded; frame_err_o set; valid_o and data_o unchanged.
REQ-020 valid_o shall stay high with data_o stable until the handshake cycle, then clear the next cycle unless a commit occurs in that same cycle.
REQ-021 Commit while valid_o high and ready_i low: new byte dropped, old data_o kept, overrun_o set.
REQ-022 Commit in the same cycle as a handshake: new byte loaded, valid_o stays high, no overrun.
REQ-023 err_clr_i clears both flags next cycle; a set event in the same cycle wins over the clear.
REQ-024 Bit-timer width shall be ceil(log2(CLKS_PER_BIT)); the timer shall never wrap inside a bit.

Reset
REQ-025 rst high at an edge: state IDLE, data_o=0x00, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0, synchronizer flops=1, timers and shift register 0.
REQ-026 rst asserted mid-frame shall abort the frame with no flag; reception restarts on the next falling edge after rst drops.

Configuration
REQ-027 Macro TKM10_RX_PARITY_EN defined: frame is 8E1; PARITY state samples one bit; mismatch with even parity of the data bits discards the byte and sets output parity_err_o (1 bit, sticky, cleared by err_clr_i and rst).
REQ-028 Macro not defined: frame is 8N1; no PARITY state; no parity_err_o port.

Verification
REQ-029 CLKS_PER_BIT=16, send 0xA5 8N1, ready_i=0 -> data_o=0xA5, valid_o=1 and held; ready_i=1 for one cycle -> valid_o=0 next cycle.
REQ-030 Low glitch of 4 cycles on idle line -> busy_o high then back to IDLE; valid_o=0, no flags.
REQ-031 Send 0x3C with stop bit forced low -> frame_err_o=1, valid_o=0; err_clr_i pulse -> frame_err_o=0.
REQ-032 Send 0x11 then 0x22 back-to-back with ready_i=0 -> data_o=0x11, overrun_o=1; with ready_i=1 throughout -> both bytes handshaken in order, overrun_o=0.
REQ-033 Assert rst during DATA bit 3 of 0xFF, release, send 0x5A -> only 0x5A delivered, no flags.
REQ-034 With TKM10_RX_PARITY_EN: 0x07 with parity bit 1 -> delivered; parity bit 0 -> parity_err_o=1, valid_o=0.
